// File: rtl/lane_phase_controller.sv
// Traffic-phase sequencer: rotates green through lane pairs with demand-based skipping,
// all-red clearance between phases, latched pedestrian walk and emergency preemption.
module lane_phase_controller #(
  parameter int NUM_LANES   = 8,
  parameter int COUNT_W     = 8,
  parameter int TIMER_W     = 8,
  parameter int DAY_TIME    = 20,
  parameter int NIGHT_TIME  = 8,
  parameter int EMG_TIME    = 10,
  parameter int PED_TIME    = 12,
  parameter int CLEAR_TIME  = 3,
  parameter int NIGHT_START = 20,
  parameter int NIGHT_END   = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [4:0]                   hoursIn,
  input  logic                         pedSignal,
  input  logic                         emgSignal,
  input  logic [NUM_LANES-1:0]         emgLane,
  input  logic [NUM_LANES*COUNT_W-1:0] laneCounts,
  output logic [NUM_LANES-1:0]         trafficLightOutput,
  output logic [NUM_LANES-1:0]         walkingLightOutput,
  output logic [1:0]                   trafficMode,
  output logic [TIMER_W-1:0]           currentCount
);

  localparam int NUM_PHASES = NUM_LANES / 2;
  localparam int PTR_W      = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  localparam bit PARAMS_OK =
      (NUM_LANES >= 2) && (NUM_LANES % 2 == 0) && (TIMER_W >= 1) && (TIMER_W <= 30) &&
      (DAY_TIME   >= 1) && (DAY_TIME   < (1 << TIMER_W)) &&
      (NIGHT_TIME >= 1) && (NIGHT_TIME < (1 << TIMER_W)) &&
      (EMG_TIME   >= 1) && (EMG_TIME   < (1 << TIMER_W)) &&
      (PED_TIME   >= 1) && (PED_TIME   < (1 << TIMER_W)) &&
      (CLEAR_TIME >= 1) && (CLEAR_TIME < (1 << TIMER_W));

  generate
    if (!PARAMS_OK) begin : g_param_check
      $error("lane_phase_controller: illegal lane count or dwell does not fit TIMER_W");
    end
  endgenerate

  localparam logic [TIMER_W-1:0] DAY_LOAD   = TIMER_W'(DAY_TIME - 1);
  localparam logic [TIMER_W-1:0] NIGHT_LOAD = TIMER_W'(NIGHT_TIME - 1);
  localparam logic [TIMER_W-1:0] EMG_LOAD   = TIMER_W'(EMG_TIME - 1);
  localparam logic [TIMER_W-1:0] PED_LOAD   = TIMER_W'(PED_TIME - 1);
  localparam logic [TIMER_W-1:0] CLEAR_LOAD = TIMER_W'(CLEAR_TIME - 1);

  localparam logic [1:0] MODE_DAY   = 2'b00;
  localparam logic [1:0] MODE_NIGHT = 2'b01;
  localparam logic [1:0] MODE_EMG   = 2'b10;
  localparam logic [1:0] MODE_PED   = 2'b11;

  typedef enum logic [1:0] {S_GREEN, S_CLEAR, S_EMG, S_PED} state_t;

  state_t               r_state,    w_state_nx;
  logic [TIMER_W-1:0]   r_timer,    w_timer_nx;
  logic [PTR_W-1:0]     r_ptr,      w_ptr_nx;
  logic                 r_ped_pend, w_ped_pend_nx;
  logic [NUM_LANES-1:0] r_emg_mask, w_emg_mask_nx;
  logic [NUM_LANES-1:0] r_green,    w_green_nx;
  logic [NUM_LANES-1:0] r_walk,     w_walk_nx;
  logic [1:0]           r_mode,     w_mode_nx;

  logic [31:0]           w_hours;
  logic                  w_night;
  logic                  w_expired;
  logic                  w_emg_req;
  logic                  w_ped_req;
  logic [NUM_PHASES-1:0] w_demand;
  logic [NUM_PHASES-1:0] w_demand_sh;
  logic [PTR_W-1:0]      w_ptr_inc;
  logic [PTR_W-1:0]      w_next_ptr;
  int                    w_idx;

  function automatic logic [NUM_LANES-1:0] phase_mask(input logic [PTR_W-1:0] p);
    logic [NUM_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_PHASES; i++) begin
      if (p == PTR_W'(i)) m[2*i +: 2] = 2'b11;
    end
    return m;
  endfunction

  assign w_hours   = {27'd0, hoursIn};
  assign w_night   = (w_hours >= NIGHT_START) || (w_hours < NIGHT_END) || (w_hours >= 32'd24);
  assign w_expired = (r_timer == '0);
  assign w_emg_req = emgSignal && (emgLane != '0);
  // A request arriving on the deciding CLEAR edge still counts as pending.
  assign w_ped_req = r_ped_pend || pedSignal;
  assign w_ptr_inc = (r_ptr == PTR_W'(NUM_PHASES - 1)) ? '0 : r_ptr + PTR_W'(1);

  always_comb begin
    w_demand = '0;
    for (int p = 0; p < NUM_PHASES; p++) begin
      w_demand[p] = (laneCounts[(2*p)*COUNT_W +: COUNT_W] != '0) ||
                    (laneCounts[(2*p+1)*COUNT_W +: COUNT_W] != '0);
    end
  end

  // Scan from the farthest candidate down so the nearest phase after the pointer wins.
  always_comb begin
    w_next_ptr  = w_ptr_inc;
    w_idx       = 0;
    w_demand_sh = '0;
    for (int k = NUM_PHASES; k >= 1; k--) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_PHASES) w_idx = w_idx - NUM_PHASES;
      w_demand_sh = w_demand >> w_idx;
      if (w_demand_sh[0]) w_next_ptr = PTR_W'(w_idx);
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    w_state_nx    = r_state;
    w_timer_nx    = r_timer - TIMER_W'(1);
    w_ptr_nx      = r_ptr;
    w_emg_mask_nx = r_emg_mask;
    w_green_nx    = r_green;
    w_walk_nx     = r_walk;
    w_mode_nx     = r_mode;
    w_ped_pend_nx = (r_state != S_PED && pedSignal) ? 1'b1 : r_ped_pend;

    unique case (r_state)
      S_GREEN: begin
        if (w_emg_req || w_expired) begin
          w_state_nx = S_CLEAR;
          w_timer_nx = CLEAR_LOAD;
          w_green_nx = '0;
          w_walk_nx  = '0;
        end
      end
      S_CLEAR: begin
        if (w_expired) begin
          if (w_emg_req) begin
            w_state_nx    = S_EMG;
            w_timer_nx    = EMG_LOAD;
            w_emg_mask_nx = emgLane;
            w_green_nx    = emgLane;
            w_walk_nx     = '0;
            w_mode_nx     = MODE_EMG;
          end else if (w_ped_req) begin
            w_state_nx    = S_PED;
            w_timer_nx    = PED_LOAD;
            w_ped_pend_nx = 1'b0;
            w_green_nx    = '0;
            w_walk_nx     = '1;
            w_mode_nx     = MODE_PED;
          end else begin
            w_state_nx = S_GREEN;
            w_timer_nx = w_night ? NIGHT_LOAD : DAY_LOAD;
            w_ptr_nx   = w_next_ptr;
            w_green_nx = phase_mask(w_next_ptr);
            w_walk_nx  = '0;
            w_mode_nx  = w_night ? MODE_NIGHT : MODE_DAY;
          end
        end
      end
      S_EMG: begin
        // The mask latched on entry stays in force; emgLane is not re-read here.
        if (w_expired) begin
          if (emgSignal) begin
            w_timer_nx = EMG_LOAD;
          end else begin
            w_state_nx = S_CLEAR;
            w_timer_nx = CLEAR_LOAD;
            w_green_nx = '0;
          end
        end
      end
      S_PED: begin
        if (w_expired) begin
          w_state_nx = S_CLEAR;
          w_timer_nx = CLEAR_LOAD;
          w_walk_nx  = '0;
        end
      end
      default: begin
        w_state_nx = S_CLEAR;
        w_timer_nx = CLEAR_LOAD;
        w_green_nx = '0;
        w_walk_nx  = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_timer    <= CLEAR_LOAD;
      r_ptr      <= PTR_W'(NUM_PHASES - 1);
      r_ped_pend <= 1'b0;
      r_emg_mask <= '0;
      r_green    <= '0;
      r_walk     <= '0;
      r_mode     <= MODE_DAY;
    end else begin
      r_state    <= w_state_nx;
      r_timer    <= w_timer_nx;
      r_ptr      <= w_ptr_nx;
      r_ped_pend <= w_ped_pend_nx;
      r_emg_mask <= w_emg_mask_nx;
      r_green    <= w_green_nx;
      r_walk     <= w_walk_nx;
      r_mode     <= w_mode_nx;
    end
  end

  assign trafficLightOutput = r_green;
  assign walkingLightOutput = r_walk;
  assign trafficMode        = r_mode;
  assign currentCount       = r_timer;

endmodule

// File: tb/tb_lane_phase_controller.sv
// Directed bench for lane_phase_controller at default parameters: reset, rotation with
// skipping, night dwell, emergency preemption, pedestrian walk and emergency/walk collision.
module tb_lane_phase_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  hoursIn;
  logic        pedSignal;
  logic        emgSignal;
  logic [7:0]  emgLane;
  logic [63:0] laneCounts;
  logic [7:0]  trafficLightOutput;
  logic [7:0]  walkingLightOutput;
  logic [1:0]  trafficMode;
  logic [7:0]  currentCount;

  int n_tests = 0;
  int n_fail  = 0;

  lane_phase_controller dut (
    .clk                (clk),
    .rst                (rst),
    .hoursIn            (hoursIn),
    .pedSignal          (pedSignal),
    .emgSignal          (emgSignal),
    .emgLane            (emgLane),
    .laneCounts         (laneCounts),
    .trafficLightOutput (trafficLightOutput),
    .walkingLightOutput (walkingLightOutput),
    .trafficMode        (trafficMode),
    .currentCount       (currentCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered from the first CLEAR cycle (count 2); leaves in the first CLEAR cycle after the green.
  task automatic run_green(input string tag, input logic [7:0] exp_out,
                           input logic [1:0] exp_mode, input int dwell);
    tick(3);
    check({tag, ".out"},   32'(trafficLightOutput), 32'(exp_out));
    check({tag, ".mode"},  32'(trafficMode),        32'(exp_mode));
    check({tag, ".walk"},  32'(walkingLightOutput), 32'h0);
    check({tag, ".first"}, 32'(currentCount),       32'(dwell - 1));
    tick(dwell - 1);
    check({tag, ".last"},     32'(currentCount),       32'h0);
    check({tag, ".last_out"}, 32'(trafficLightOutput), 32'(exp_out));
    tick(1);
    check({tag, ".clr_out"},  32'(trafficLightOutput), 32'h0);
    check({tag, ".clr_cnt"},  32'(currentCount),       32'h2);
    check({tag, ".clr_mode"}, 32'(trafficMode),        32'(exp_mode));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    hoursIn    = 5'd12;
    pedSignal  = 1'b0;
    emgSignal  = 1'b0;
    emgLane    = 8'h00;
    laneCounts = '0;

    // Reset
    tick(1);
    check("rst.out",  32'(trafficLightOutput), 32'h0);
    check("rst.walk", 32'(walkingLightOutput), 32'h0);
    check("rst.mode", 32'(trafficMode),        32'h0);
    check("rst.cnt",  32'(currentCount),       32'h2);
    rst = 1'b0;
    run_green("boot_ph0", 8'h03, 2'b00, 20);

    // Demand only in lanes 7 and 2: phases 1 and 3 alternate
    laneCounts[7*8 +: 8] = 8'd5;
    laneCounts[2*8 +: 8] = 8'd3;
    run_green("skip_ph1a", 8'h0C, 2'b00, 20);
    run_green("skip_ph3",  8'hC0, 2'b00, 20);
    run_green("skip_ph1b", 8'h0C, 2'b00, 20);

    // Night window and out-of-range hour
    hoursIn = 5'd22;
    run_green("night22", 8'hC0, 2'b01, 8);
    hoursIn = 5'd25;
    run_green("night25", 8'h0C, 2'b01, 8);
    hoursIn = 5'd6;
    run_green("day6",    8'hC0, 2'b00, 20);

    // Emergency truncation of phase 0, reload while held, release
    hoursIn    = 5'd12;
    laneCounts = '0;
    tick(3);
    check("emg.ph0", 32'(trafficLightOutput), 32'h03);
    tick(5);
    emgSignal = 1'b1;
    emgLane   = 8'h08;
    tick(1);
    check("emg.trunc_out", 32'(trafficLightOutput), 32'h0);
    check("emg.trunc_cnt", 32'(currentCount),       32'h2);
    tick(3);
    check("emg.out",  32'(trafficLightOutput), 32'h08);
    check("emg.mode", 32'(trafficMode),        32'h2);
    check("emg.cnt",  32'(currentCount),       32'h9);
    emgLane = 8'h01;
    tick(10);
    check("emg.reload1",  32'(currentCount),       32'h9);
    check("emg.mask_held", 32'(trafficLightOutput), 32'h08);
    tick(10);
    check("emg.reload2", 32'(currentCount), 32'h9);
    emgSignal = 1'b0;
    tick(9);
    check("emg.last", 32'(currentCount),       32'h0);
    check("emg.last_out", 32'(trafficLightOutput), 32'h08);
    tick(1);
    check("emg.clr_out",  32'(trafficLightOutput), 32'h0);
    check("emg.clr_mode", 32'(trafficMode),        32'h2);
    check("emg.clr_cnt",  32'(currentCount),       32'h2);
    // emgSignal with an empty lane mask must be ignored
    emgSignal = 1'b1;
    emgLane   = 8'h00;
    run_green("resume_ph1", 8'h0C, 2'b00, 20);
    emgSignal = 1'b0;

    // Pedestrian pulse in GREEN, second pulse inside PED ignored
    tick(3);
    check("ped.ph2", 32'(trafficLightOutput), 32'h30);
    pedSignal = 1'b1;
    tick(1);
    pedSignal = 1'b0;
    check("ped.no_trunc", 32'(currentCount), 32'd18);
    tick(18);
    check("ped.green_last", 32'(trafficLightOutput), 32'h30);
    tick(1);
    check("ped.clr_out", 32'(trafficLightOutput), 32'h0);
    tick(3);
    check("ped.walk", 32'(walkingLightOutput), 32'hFF);
    check("ped.out",  32'(trafficLightOutput), 32'h0);
    check("ped.mode", 32'(trafficMode),        32'h3);
    check("ped.cnt",  32'(currentCount),       32'd11);
    pedSignal = 1'b1;
    tick(1);
    pedSignal = 1'b0;
    tick(10);
    check("ped.last", 32'(currentCount),       32'h0);
    check("ped.last_walk", 32'(walkingLightOutput), 32'hFF);
    tick(1);
    check("ped.clr_walk", 32'(walkingLightOutput), 32'h0);
    check("ped.clr_mode", 32'(trafficMode),        32'h3);
    tick(3);
    check("ped.no_second", 32'(trafficLightOutput), 32'hC0);
    check("ped.after_mode", 32'(trafficMode),       32'h0);

    // Emergency and pedestrian on the same CLEAR expiry: EMG first, then PED
    tick(19);
    tick(1);
    tick(2);
    check("col.clr_last", 32'(currentCount), 32'h0);
    emgSignal = 1'b1;
    emgLane   = 8'h20;
    pedSignal = 1'b1;
    tick(1);
    pedSignal = 1'b0;
    emgSignal = 1'b0;
    check("col.emg_out",  32'(trafficLightOutput), 32'h20);
    check("col.emg_mode", 32'(trafficMode),        32'h2);
    tick(10);
    check("col.clr_out", 32'(trafficLightOutput), 32'h0);
    tick(3);
    check("col.ped_walk", 32'(walkingLightOutput), 32'hFF);
    check("col.ped_mode", 32'(trafficMode),        32'h3);

    // Reset in the middle of PED
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst.walk", 32'(walkingLightOutput), 32'h0);
    check("mid_rst.mode", 32'(trafficMode),        32'h0);
    check("mid_rst.cnt",  32'(currentCount),       32'h2);
    tick(3);
    check("mid_rst.ph0", 32'(trafficLightOutput), 32'h03);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lane_phase_controller.md
# lane_phase_controller

Parametrised traffic-phase sequencer for the intersection Breadboard. It drives per-lane green and walk lights from lane occupancy counts, time of day, pedestrian requests and emergency preemption. It generalises the fixed 8-lane controller to NUM_LANES lanes, with demand-based phase skipping, an all-red clearance interval and a latched pedestrian request.

## Interface
- NUM_LANES, 8, lane count; must be even; phase p = lanes {2p+1, 2p}; NUM_PHASES = NUM_LANES/2
- COUNT_W, 8, width of each lane occupancy count
- TIMER_W, 8, width of the dwell timer
- DAY_TIME, 20, green dwell in day mode (cycles, ≥1)
- NIGHT_TIME, 8, green dwell in night mode (≥1)
- EMG_TIME, 10, emergency dwell per reload (≥1)
- PED_TIME, 12, pedestrian walk dwell (≥1)
- CLEAR_TIME, 3, all-red clearance dwell (≥1)
- NIGHT_START, 20 / NIGHT_END, 6, night-window hour bounds

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- hoursIn  in  5  hour of day
- pedSignal  in  1  pedestrian request (pulse or level)
- emgSignal  in  1  emergency active (level)
- emgLane  in  NUM_LANES  lanes to serve during an emergency
- laneCounts  in  NUM_LANES*COUNT_W  lane i occupancy in bits [i*COUNT_W +: COUNT_W]
- trafficLightOutput  out  NUM_LANES  1 = green for lane i
- walkingLightOutput  out  NUM_LANES  1 = walk for lane i
- trafficMode  out  2  00 day, 01 night, 10 emergency, 11 pedestrian
- currentCount  out  TIMER_W  remaining dwell cycles minus one

## Operation
- States: GREEN, CLEAR, EMG, PED. A registered phase pointer (0..NUM_PHASES-1) and a latched emergency lane mask `emgMask` are held.
- Night is true when hoursIn ≥ NIGHT_START, hoursIn < NIGHT_END, or hoursIn ≥ 24. It is sampled only when GREEN is loaded.
- Phase demand: OR over the two lanes of the phase of (count ≠ 0).
- GREEN: lanes of the current phase are green, walk is 0, mode is 00 or 01 according to night at load. On timer expiry, go to CLEAR. If emgSignal=1 and emgLane≠0, go to CLEAR on the next edge (truncation); the timer value is discarded.
- CLEAR: all green and walk bits are 0. Mode holds its previous value. At expiry, decide in priority order:
  1. emgSignal=1 and emgLane≠0: go to EMG, latch emgMask=emgLane, load EMG_TIME.
  2. Pedestrian request pending: go to PED, load PED_TIME, clear the pending flag.
  3. Otherwise: go to GREEN on the first phase with demand, searching pointer+1 upward with wrap. If no phase has demand, use pointer+1 (mod NUM_PHASES). Load DAY_TIME or NIGHT_TIME.
- EMG: trafficLightOutput=emgMask, mode 10. At expiry, reload EMG_TIME if emgSignal is still 1; otherwise go to CLEAR. emgLane changes while in EMG are ignored.
- PED: all traffic outputs 0, walkingLightOutput all 1, mode 11. At expiry, go to CLEAR.
- The pending flag is set by pedSignal=1 on any edge outside PED. pedSignal in PED is ignored. pedSignal never truncates GREEN.
- emgSignal=1 with emgLane=0 is ignored everywhere.
- The phase pointer changes only when GREEN is entered.

## Timing
- Dwell: a state loaded with T lasts exactly T cycles. currentCount = T-1 on the first cycle and decrements by 1 per cycle. The transition occurs on the edge where currentCount=0.
- Reset (rst=1 at an edge): state CLEAR, currentCount=CLEAR_TIME-1, phase pointer=NUM_PHASES-1, pending flag=0, emgMask=0, trafficLightOutput=0, walkingLightOutput=0, trafficMode=00.
- Reset mid-operation overrides every state and latch on the same edge.
- All outputs are registered and change only at the transition edge. There is no combinational path from inputs to outputs.
- Emergency truncation latency: emgSignal sampled high in GREEN gives all-red on the next edge. EMG green follows CLEAR_TIME cycles later.
- A pedSignal and an expiry on the same CLEAR edge: the request counts as pending and wins unless an emergency is also present.
- Timer arithmetic is unsigned TIMER_W. Parameters must fit in TIMER_W (checked at elaboration).

## Test plan
- Reset: rst high 1 cycle → all outputs 0, trafficMode=00, currentCount=2. After 3 cycles, phase 0 green (out=8'b00000011) for 20 cycles.
- Skipping: demand only in lanes 7 and 2, hoursIn=12 → green sequence phase1 (8'b00001100), phase3 (8'b11000000), phase1, with 3-cycle all-red between each.
- Night: hoursIn=22, then hoursIn=25 → GREEN dwell 8 cycles and mode 01 in both cases. hoursIn=6 → 20 cycles, mode 00.
- Emergency: emgSignal=1, emgLane=8'b00001000 mid-GREEN on phase 0 → all-red next edge, then out=8'b00001000, mode 10. Held for 25 cycles → EMG reloaded. Release → CLEAR, then normal rotation resumes from pointer+1.
- Pedestrian: 1-cycle pedSignal pulse during GREEN → GREEN completes its full dwell, then CLEAR, then walk=8'hFF for 12 cycles, then CLEAR. A second pulse during PED produces no second PED.
- Collision: emgSignal and pedSignal both high at CLEAR expiry → EMG first. After emergency release and CLEAR → PED.
